// File: rtl/decode_execute_reg_pkg.sv
// Shared ID/EX pipeline definitions: widths, bubble word, field slices, control bundle.
package decode_execute_reg_pkg;

    localparam int          DATA_W     = 16;
    localparam int          REG_ADDR_W = 3;
    localparam int          CNT_W      = 16;
    localparam logic [15:0] NOP_INSTR  = 16'h0800;

    // Register specifier fields inside an instruction word; forwarding uses the same slices.
    localparam int RS_HI = 10;
    localparam int RS_LO = 8;
    localparam int RT_HI = 7;
    localparam int RT_LO = 5;

    // Control that travels with an instruction from decode into execute.
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] writereg;
    } idex_ctrl_t;

    // Control contents of a bubble: nothing valid, nothing written.
    function automatic idex_ctrl_t bubble_ctrl();
        return '0;
    endfunction

endpackage

// File: rtl/decode_execute_reg_if.sv
// Decode-to-execute bus: decode-side inputs, execute-side register outputs, stall status.
interface decode_execute_reg_if #(
    parameter int DATA_W     = decode_execute_reg_pkg::DATA_W,
    parameter int REG_ADDR_W = decode_execute_reg_pkg::REG_ADDR_W,
    parameter int CNT_W      = decode_execute_reg_pkg::CNT_W
) ();
    logic [DATA_W-1:0]     ID_Instr;
    logic                  ID_valid;
    logic                  ID_uses_rs;
    logic                  ID_uses_rt;
    logic [DATA_W-1:0]     ID_read1data;
    logic [DATA_W-1:0]     ID_read2data;
    logic                  ID_regWrite;
    logic                  ID_memRead;
    logic [REG_ADDR_W-1:0] ID_writereg;
    logic                  flush;
    logic                  mem_stall;

    logic [DATA_W-1:0]     IE_Instr_out;
    logic [DATA_W-1:0]     IE_read1data_out;
    logic [DATA_W-1:0]     IE_read2data_out;
    logic                  IE_regWrite_out;
    logic                  IE_memRead_out;
    logic [REG_ADDR_W-1:0] IE_writereg_out;
    logic                  IE_valid_out;
    logic                  stall_out;
    logic [CNT_W-1:0]      lu_stall_count;

    // Pipeline side that drives decode and observes execute.
    modport master (
        output ID_Instr, ID_valid, ID_uses_rs, ID_uses_rt, ID_read1data, ID_read2data,
               ID_regWrite, ID_memRead, ID_writereg, flush, mem_stall,
        input  IE_Instr_out, IE_read1data_out, IE_read2data_out, IE_regWrite_out,
               IE_memRead_out, IE_writereg_out, IE_valid_out, stall_out, lu_stall_count
    );

    // The ID/EX register itself.
    modport slave (
        input  ID_Instr, ID_valid, ID_uses_rs, ID_uses_rt, ID_read1data, ID_read2data,
               ID_regWrite, ID_memRead, ID_writereg, flush, mem_stall,
        output IE_Instr_out, IE_read1data_out, IE_read2data_out, IE_regWrite_out,
               IE_memRead_out, IE_writereg_out, IE_valid_out, stall_out, lu_stall_count
    );
endinterface

// File: rtl/decode_execute_reg_load_use_detect.sv
// Load-use compare: a valid load ahead writes a register the younger instruction reads.
// Pure combinational so a later stage can reuse it with its own control bundle.
module load_use_detect
    import decode_execute_reg_pkg::*;
(
    input  idex_ctrl_t            ahead,
    input  logic                  id_valid,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  hazard
);
    logic rs_hit;
    logic rt_hit;

    // Register 0 is compared like any other specifier.
    assign rs_hit = id_uses_rs && (ahead.writereg == id_rs);
    assign rt_hit = id_uses_rt && (ahead.writereg == id_rt);

    assign hazard = ahead.valid && ahead.mem_read && ahead.reg_write && id_valid
                    && (rs_hit || rt_hit);
endmodule

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module decode_execute_reg #(
    parameter int          DATA_W     = decode_execute_reg_pkg::DATA_W,
    parameter int          REG_ADDR_W = decode_execute_reg_pkg::REG_ADDR_W,
    parameter logic [15:0] NOP_INSTR  = decode_execute_reg_pkg::NOP_INSTR,
    parameter int          CNT_W      = decode_execute_reg_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_execute_reg_if.slave  bus
);
    import decode_execute_reg_pkg::*;

    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    idex_ctrl_t        ctrl_q;
    idex_ctrl_t        ctrl_cap;
    logic [CNT_W-1:0]  cnt_q;
    logic              lu_hazard;

    load_use_detect u_lud (
        .ahead      (ctrl_q),
        .id_valid   (bus.ID_valid),
        .id_uses_rs (bus.ID_uses_rs),
        .id_uses_rt (bus.ID_uses_rt),
        .id_rs      (bus.ID_Instr[RS_HI:RS_LO]),
        .id_rt      (bus.ID_Instr[RT_HI:RT_LO]),
        .hazard     (lu_hazard)
    );

    // Control captured from decode; an invalid slot never writes or loads.
    always_comb begin
        ctrl_cap           = bubble_ctrl();
        ctrl_cap.valid     = bus.ID_valid;
        ctrl_cap.reg_write = bus.ID_regWrite & bus.ID_valid;
        ctrl_cap.mem_read  = bus.ID_memRead & bus.ID_valid;
        ctrl_cap.writereg  = bus.ID_writereg;
    end

    // Pipeline register: freeze on mem_stall, bubble on flush or load-use, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= DATA_W'(NOP_INSTR);
            rd1_q   <= '0;
            rd2_q   <= '0;
            ctrl_q  <= bubble_ctrl();
            cnt_q   <= '0;
        end else if (bus.mem_stall) begin
            instr_q <= instr_q;
        end else if (bus.flush || lu_hazard) begin
            instr_q <= DATA_W'(NOP_INSTR);
            rd1_q   <= '0;
            rd2_q   <= '0;
            ctrl_q  <= bubble_ctrl();
            // A flush squashes the dependent instruction, so it is not a load-use bubble.
            if (!bus.flush && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end else begin
            instr_q <= bus.ID_Instr;
            rd1_q   <= bus.ID_read1data;
            rd2_q   <= bus.ID_read2data;
            ctrl_q  <= ctrl_cap;
        end
    end

    // Front-end hold; forced low while reset is asserted.
    assign bus.stall_out = rst_n & (bus.mem_stall | (lu_hazard & ~bus.flush));

    assign bus.IE_Instr_out     = instr_q;
    assign bus.IE_read1data_out = rd1_q;
    assign bus.IE_read2data_out = rd2_q;
    assign bus.IE_regWrite_out  = ctrl_q.reg_write;
    assign bus.IE_memRead_out   = ctrl_q.mem_read;
    assign bus.IE_writereg_out  = ctrl_q.writereg;
    assign bus.IE_valid_out     = ctrl_q.valid;
    assign bus.lu_stall_count   = cnt_q;
endmodule

// File: tb/tb_decode_execute_reg.sv
// Randomized + directed bench for decode_execute_reg against a behavioural model.
module tb_decode_execute_reg;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 4;   // narrow counter so saturation is reachable quickly
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_execute_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    decode_execute_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .NOP_INSTR(16'h0800), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Model of what execute should hold.
    logic [15:0] m_instr, m_d1, m_d2;
    logic        m_rw, m_mr, m_v;
    logic [2:0]  m_wr;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic bit m_hazard();
        bit dep;
        dep = (bus.ID_uses_rs && m_wr == bus.ID_Instr[10:8]) ||
              (bus.ID_uses_rt && m_wr == bus.ID_Instr[7:5]);
        return m_v && m_mr && m_rw && bus.ID_valid && dep;
    endfunction

    function automatic bit m_stall();
        return rst_n && (bus.mem_stall || (m_hazard() && !bus.flush));
    endfunction

    task automatic m_bubble();
        m_instr = 16'h0800; m_d1 = 0; m_d2 = 0; m_rw = 0; m_mr = 0; m_v = 0; m_wr = 0;
    endtask

    task automatic m_edge();
        bit h;
        h = m_hazard();
        if (bus.mem_stall) return;
        if (bus.flush) m_bubble();
        else if (h) begin
            m_bubble();
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            m_instr = bus.ID_Instr; m_d1 = bus.ID_read1data; m_d2 = bus.ID_read2data;
            m_v = bus.ID_valid; m_rw = bus.ID_regWrite && bus.ID_valid;
            m_mr = bus.ID_memRead && bus.ID_valid; m_wr = bus.ID_writereg;
        end
    endtask

    task automatic check_all();
        chk("instr",  bus.IE_Instr_out,     m_instr);
        chk("rd1",    bus.IE_read1data_out, m_d1);
        chk("rd2",    bus.IE_read2data_out, m_d2);
        chk("rw",     bus.IE_regWrite_out,  m_rw);
        chk("mr",     bus.IE_memRead_out,   m_mr);
        chk("wr",     bus.IE_writereg_out,  m_wr);
        chk("valid",  bus.IE_valid_out,     m_v);
        chk("count",  bus.lu_stall_count,   m_cnt);
        chk("stall",  bus.stall_out,        m_stall());
    endtask

    task automatic drive(input logic [15:0] instr, input bit v, input bit urs, input bit urt,
                         input bit rw, input bit mr, input logic [2:0] wr,
                         input bit fl, input bit ms);
        bus.ID_Instr = instr; bus.ID_valid = v; bus.ID_uses_rs = urs; bus.ID_uses_rt = urt;
        bus.ID_read1data = 16'($urandom); bus.ID_read2data = 16'($urandom);
        bus.ID_regWrite = rw; bus.ID_memRead = mr; bus.ID_writereg = wr;
        bus.flush = fl; bus.mem_stall = ms;
    endtask

    // Inputs are set just after a falling edge; check, clock, advance model.
    task automatic step();
        #1 check_all();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic load_r3();
        drive(16'h8060, 1, 0, 0, 1, 1, 3'd3, 0, 0);
        step();
    endtask

    initial begin
        m_bubble(); m_cnt = 0;
        drive(16'h0000, 0, 0, 0, 0, 0, 3'd0, 0, 0);

        // 1: reset values, then a plain capture
        @(negedge clk);
        #1 check_all();
        chk("rst_instr", bus.IE_Instr_out, 16'h0800);
        chk("rst_stall", bus.stall_out, 1'b0);
        rst_n = 1'b1;
        drive(16'h4123, 1, 1, 0, 1, 0, 3'd1, 0, 0);
        step();
        chk("t1_instr", bus.IE_Instr_out, 16'h4123);
        chk("t1_valid", bus.IE_valid_out, 1'b1);

        // 2: load r3 then rs-dependent -> one bubble
        load_r3();
        drive(16'h4300, 1, 1, 0, 1, 0, 3'd1, 0, 0);
        #1 chk("t2_stall", bus.stall_out, 1'b1);
        step();
        chk("t2_bub_instr", bus.IE_Instr_out, 16'h0800);
        chk("t2_bub_valid", bus.IE_valid_out, 1'b0);
        chk("t2_count", bus.lu_stall_count, 4'd1);
        chk("t2_stall_clear", bus.stall_out, 1'b0);
        step();
        chk("t2_capture", bus.IE_Instr_out, 16'h4300);

        // 3: rt field matches but unused; ALU writer to r3 is not a load
        load_r3();
        drive(16'h0060, 1, 1, 0, 1, 0, 3'd3, 0, 0);
        #1 chk("t3_rt_unused", bus.stall_out, 1'b0);
        step();
        drive(16'h4300, 1, 1, 0, 1, 0, 3'd2, 0, 0);
        #1 chk("t3_alu_writer", bus.stall_out, 1'b0);
        step();

        // 4: flush beats load-use
        load_r3();
        drive(16'h4300, 1, 1, 0, 1, 0, 3'd1, 1, 0);
        #1 chk("t4_stall", bus.stall_out, 1'b0);
        step();
        chk("t4_instr", bus.IE_Instr_out, 16'h0800);
        chk("t4_count", bus.lu_stall_count, 4'd1);

        // 5: mem_stall freezes a valid IE for three cycles, even with a hazard pending
        load_r3();
        for (int i = 0; i < 3; i++) begin
            drive(16'h4300, 1, 1, 0, 1, 0, 3'd1, 0, 1);
            step();
            chk("t5_frozen", bus.IE_Instr_out, 16'h8060);
            chk("t5_cnt_frozen", bus.lu_stall_count, 4'd1);
        end
        drive(16'h4300, 1, 1, 0, 1, 0, 3'd1, 0, 0);
        step();
        chk("t5_after_release", bus.lu_stall_count, 4'd2);
        for (int i = 0; i < CMAX + 2; i++) begin
            load_r3();
            drive(16'h4060, 1, 0, 1, 1, 0, 3'd1, 0, 0);
            step();
        end
        chk("t5_saturate", bus.lu_stall_count, 4'hF);

        // 6: asynchronous reset between edges during a stall
        load_r3();
        drive(16'h4300, 1, 1, 0, 1, 0, 3'd1, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_instr", bus.IE_Instr_out, 16'h0800);
        chk("t6_valid", bus.IE_valid_out, 1'b0);
        chk("t6_count", bus.lu_stall_count, 4'd0);
        chk("t6_stall", bus.stall_out, 1'b0);
        m_bubble(); m_cnt = 0;
        @(negedge clk);
        drive(16'h0000, 0, 0, 0, 0, 0, 3'd0, 0, 0);
        rst_n = 1'b1;

        // Random traffic biased toward r3 dependencies
        for (int i = 0; i < 600; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 1)) ins[10:8] = 3'd3;
            if ($urandom_range(0, 1)) ins[7:5]  = 3'd3;
            drive(ins, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom),
                  $urandom_range(0, 1) ? 3'd3 : 3'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
